// File: rtl/mat_pkg.sv
// Shared matrix types for the row store and the LU/inverse engines.
// Complex elements are packed {im, re}; rows pack element 0 in the low bits.
package mat_pkg;

  localparam int MAT_SIZE  = 4;
  localparam int MAT_WIDTH = 64;

  typedef struct packed {
    logic [MAT_WIDTH-1:0] im;
    logic [MAT_WIDTH-1:0] re;
  } cplx_t;

  typedef cplx_t [MAT_SIZE-1:0] row_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLR
  } rs_state_e;

endpackage

// File: rtl/mat_row_store_if.sv
// Request/response bundle of the matrix row store.
// The master (loader or engine) drives requests; the slave is the store.
interface mat_row_store_if #(
  parameter int SIZE      = 4,
  parameter int WIDTH     = 64,
  parameter int NUM_BANKS = 2
);
  localparam int ROW_W = SIZE * 2 * WIDTH;
  localparam int AW    = $clog2(SIZE);
  localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic             rd_valid_i;
  logic [BW-1:0]    rd_bank_i;
  logic [AW-1:0]    rd_addr_i;
  logic [ROW_W-1:0] rd_row_o;
  logic             rd_valid_o;
  logic [AW-1:0]    rd_addr_o;
  logic             wr_valid_i;
  logic [BW-1:0]    wr_bank_i;
  logic [AW-1:0]    wr_addr_i;
  logic [ROW_W-1:0] wr_row_i;
  logic             swap_valid_i;
  logic [BW-1:0]    swap_bank_i;
  logic [AW-1:0]    swap_a_i;
  logic [AW-1:0]    swap_b_i;
  logic             perm_clr_i;
  logic [BW-1:0]    perm_clr_bank_i;
  logic [SIZE*AW-1:0] perm_o;
  logic             ready_o;
  logic             busy_o;

  modport master (
    output rd_valid_i, rd_bank_i, rd_addr_i,
    output wr_valid_i, wr_bank_i, wr_addr_i, wr_row_i,
    output swap_valid_i, swap_bank_i, swap_a_i, swap_b_i,
    output perm_clr_i, perm_clr_bank_i,
    input  rd_row_o, rd_valid_o, rd_addr_o, perm_o, ready_o, busy_o
  );

  modport slave (
    input  rd_valid_i, rd_bank_i, rd_addr_i,
    input  wr_valid_i, wr_bank_i, wr_addr_i, wr_row_i,
    input  swap_valid_i, swap_bank_i, swap_a_i, swap_b_i,
    input  perm_clr_i, perm_clr_bank_i,
    output rd_row_o, rd_valid_o, rd_addr_o, perm_o, ready_o, busy_o
  );

endinterface

// File: rtl/perm_table.sv
// One bank's logical-to-physical row map: single-cycle swap plus identity fill at idx_i.
// No reset: the owner fills every entry before the table is used.
module perm_table #(
  parameter int SIZE = 4,
  parameter int AW   = 2
) (
  input  logic                     clk_i,
  input  logic                     fill_i,
  input  logic [AW-1:0]            idx_i,
  input  logic                     swap_i,
  input  logic [AW-1:0]            a_i,
  input  logic [AW-1:0]            b_i,
  output logic [SIZE-1:0][AW-1:0]  perm_o
);

  logic [SIZE-1:0][AW-1:0] perm_q, perm_d;

  // Fill wins over swap so a swap accepted with a clear is overwritten.
  always_comb begin
    perm_d = perm_q;
    if (swap_i) begin
      perm_d[a_i] = perm_q[b_i];
      perm_d[b_i] = perm_q[a_i];
    end
    if (fill_i) begin
      perm_d[idx_i] = idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    perm_q <= perm_d;
  end

  assign perm_o = perm_q;

endmodule

// File: rtl/mat_row_store.sv
// Banked complex-matrix row store with per-bank row permutation for pivoting.
// MAT_ROW_STORE_ZERO_INIT_EN: INIT also zeroes the data rows of every bank.
module mat_row_store
  import mat_pkg::*;
#(
  parameter int SIZE      = MAT_SIZE,
  parameter int WIDTH     = MAT_WIDTH,
  parameter int NUM_BANKS = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mat_row_store_if.slave bus
);

  localparam int ROW_W = SIZE * 2 * WIDTH;
  localparam int AW    = $clog2(SIZE);
  localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BW:0] NB = (BW+1)'(NUM_BANKS);

  rs_state_e        state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [BW-1:0]    clr_bank_q, clr_bank_d;
  logic             ready, busy, fill_all, fill_clr;
  logic             rd_in, wr_in, sw_in, clr_in;
  logic             rd_acc, wr_acc, sw_acc, clr_acc;
  logic [AW-1:0]    rd_phys, wr_phys;
  logic [ROW_W-1:0] rd_row_q;
  logic             rd_valid_q;
  logic [AW-1:0]    rd_addr_q;

  logic [NUM_BANKS-1:0][SIZE-1:0][AW-1:0] perm_w;
  logic [ROW_W-1:0] mem_q [NUM_BANKS][SIZE];

  assign rd_in  = {1'b0, bus.rd_bank_i} < NB;
  assign wr_in  = {1'b0, bus.wr_bank_i} < NB;
  assign sw_in  = {1'b0, bus.swap_bank_i} < NB;
  assign clr_in = {1'b0, bus.perm_clr_bank_i} < NB;

  // An out-of-range read still answers (with zero data); other requests vanish.
  assign rd_acc  = ready & bus.rd_valid_i;
  assign wr_acc  = ready & bus.wr_valid_i & wr_in;
  assign sw_acc  = ready & bus.swap_valid_i & sw_in;
  assign clr_acc = ready & bus.perm_clr_i & clr_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      idx_q      <= '0;
      clr_bank_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_bank_q <= clr_bank_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_bank_d = clr_bank_q;
    unique case (state_q)
      INIT, CLR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(SIZE - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      IDLE: begin
        if (clr_acc) begin
          state_d    = CLR;
          clr_bank_d = bus.perm_clr_bank_i;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    busy     = 1'b1;
    fill_all = 1'b0;
    fill_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      INIT:    fill_all = 1'b1;
      CLR:     fill_clr = 1'b1;
      default: fill_all = 1'b0;
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic fill_b, swap_b;
    assign fill_b = fill_all | (fill_clr && (clr_bank_q == BW'(b)));
    assign swap_b = sw_acc && (bus.swap_bank_i == BW'(b));
    perm_table #(.SIZE(SIZE), .AW(AW)) u_perm (
      .clk_i  (clk_i),
      .fill_i (fill_b),
      .idx_i  (idx_q),
      .swap_i (swap_b),
      .a_i    (bus.swap_a_i),
      .b_i    (bus.swap_b_i),
      .perm_o (perm_w[b])
    );
  end

  // Both translations see the table as it was before this edge.
  assign rd_phys = rd_in ? perm_w[bus.rd_bank_i][bus.rd_addr_i] : '0;
  assign wr_phys = wr_in ? perm_w[bus.wr_bank_i][bus.wr_addr_i] : '0;

  always_ff @(posedge clk_i) begin
`ifdef MAT_ROW_STORE_ZERO_INIT_EN
    if (state_q == INIT) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem_q[b][idx_q] <= '0;
      end
    end
`endif
    if (wr_acc) begin
      mem_q[bus.wr_bank_i][wr_phys] <= bus.wr_row_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_row_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_addr_q <= bus.rd_addr_i;
        rd_row_q  <= rd_in ? mem_q[bus.rd_bank_i][rd_phys] : '0;
      end
    end
  end

  assign bus.rd_row_o   = rd_row_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_addr_o  = rd_addr_q;
  assign bus.perm_o     = rd_in ? perm_w[bus.rd_bank_i] : '0;
  assign bus.ready_o    = ready;
  assign bus.busy_o     = busy;

endmodule

// File: tb/tb_mat_row_store.sv
// Randomised bench for mat_row_store against a logical-row reference model.
// The model tracks what each logical row holds; the permutation only matters for perm_o and clears.
module tb_mat_row_store;
  import mat_pkg::*;

  localparam int SZ    = MAT_SIZE;
  localparam int WD    = MAT_WIDTH;
  localparam int NB    = 2;
  localparam int ROW_W = SZ * 2 * WD;
  localparam int AW    = $clog2(SZ);
  localparam int BW    = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mat_row_store_if #(.SIZE(SZ), .WIDTH(WD), .NUM_BANKS(NB)) bus ();

  mat_row_store #(.SIZE(SZ), .WIDTH(WD), .NUM_BANKS(NB)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [ROW_W-1:0] lrow   [NB][SZ];
  int               perm_m [NB][SZ];

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [SZ*AW-1:0] exp_perm(int b);
    logic [SZ*AW-1:0] p;
    for (int i = 0; i < SZ; i++) p[i*AW +: AW] = AW'(perm_m[b][i]);
    return p;
  endfunction

  task automatic clear_inputs();
    bus.rd_valid_i = 0; bus.rd_bank_i = '0; bus.rd_addr_i = '0;
    bus.wr_valid_i = 0; bus.wr_bank_i = '0; bus.wr_addr_i = '0; bus.wr_row_i = '0;
    bus.swap_valid_i = 0; bus.swap_bank_i = '0; bus.swap_a_i = '0; bus.swap_b_i = '0;
    bus.perm_clr_i = 0; bus.perm_clr_bank_i = '0;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < SZ; i++) begin
        perm_m[b][i] = i;
`ifdef MAT_ROW_STORE_ZERO_INIT_EN
        lrow[b][i] = '0;
`else
        lrow[b][i] = 'x;
`endif
      end
  endtask

  // Drives one cycle of requests (store assumed ready), advances the model, returns expected read data.
  task automatic drive_cycle(input bit rd, input int rb, input int ra,
                             input bit wr, input int wb, input int wa, input logic [ROW_W-1:0] wd,
                             input bit sw, input int sb, input int sa, input int sbb,
                             input bit clr, input int cb, output logic [ROW_W-1:0] exp_rd);
    logic [ROW_W-1:0] phys [SZ];
    logic [ROW_W-1:0] t;
    int tp;
    bus.rd_valid_i = rd; bus.rd_bank_i = BW'(rb); bus.rd_addr_i = AW'(ra);
    bus.wr_valid_i = wr; bus.wr_bank_i = BW'(wb); bus.wr_addr_i = AW'(wa); bus.wr_row_i = wd;
    bus.swap_valid_i = sw; bus.swap_bank_i = BW'(sb); bus.swap_a_i = AW'(sa); bus.swap_b_i = AW'(sbb);
    bus.perm_clr_i = clr; bus.perm_clr_bank_i = BW'(cb);
    exp_rd = lrow[rb][ra];
    @(posedge clk); #1;
    bus.rd_valid_i = 0; bus.wr_valid_i = 0; bus.swap_valid_i = 0; bus.perm_clr_i = 0;
    if (wr) lrow[wb][wa] = wd;
    if (sw) begin
      t = lrow[sb][sa]; lrow[sb][sa] = lrow[sb][sbb]; lrow[sb][sbb] = t;
      tp = perm_m[sb][sa]; perm_m[sb][sa] = perm_m[sb][sbb]; perm_m[sb][sbb] = tp;
    end
    if (clr) begin
      for (int j = 0; j < SZ; j++) phys[perm_m[cb][j]] = lrow[cb][j];
      for (int i = 0; i < SZ; i++) begin
        lrow[cb][i] = phys[i];
        perm_m[cb][i] = i;
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.rd_valid_o !== 1'b0 ||
        bus.rd_addr_o !== '0 || bus.rd_row_o !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b busy=%b rd_valid=%b rd_addr=%0d row_nonzero=%b, required 0 1 0 0 0",
               tag, bus.ready_o, bus.busy_o, bus.rd_valid_o, bus.rd_addr_o, |bus.rd_row_o);
    end
  endtask

  task automatic release_and_init(input string tag);
    int n;
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != SZ) begin
      errors++;
      $display("FAIL %s_ready_latency: ready after %0d cycles, required %0d", tag, n, SZ);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: busy=%b with ready high, required 0", tag, bus.busy_o);
    end
    model_reset();
    bus.rd_bank_i = '0; #1;
    checks++;
    if (bus.perm_o !== 8'hE4) begin
      errors++;
      $display("FAIL %s_perm_identity: perm_o=%h, required e4", tag, bus.perm_o);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset_values");
    repeat (2) @(posedge clk);
    #1 release_and_init("reset");
  endtask

  task automatic test_write_read();
    logic [ROW_W-1:0] e, held;
    row_t r;
    for (int i = 0; i < SZ; i++) begin
      for (int k = 0; k < SZ; k++) begin
        r[k].re = $realtobits(real'(i));
        r[k].im = {$urandom, $urandom};
      end
      drive_cycle(0, 0, 0, 1, 0, i, r, 0, 0, 0, 0, 0, 0, e);
      checks++;
      if (bus.rd_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL wr_no_rd_valid: rd_valid=%b, required 0", bus.rd_valid_o);
      end
    end
    for (int i = 0; i < SZ; i++) drive_cycle(0, 0, 0, 1, 1, i, rand_row(), 0, 0, 0, 0, 0, 0, e);
    drive_cycle(1, 0, 2, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (bus.rd_valid_o !== 1'b1 || bus.rd_addr_o !== AW'(2) || bus.rd_row_o !== e) begin
      errors++;
      $display("FAIL read_row2: valid=%b addr=%0d re0=%h, required 1 2 %h",
               bus.rd_valid_o, bus.rd_addr_o, bus.rd_row_o[WD-1:0], e[WD-1:0]);
    end
    held = e;
    drive_cycle(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (bus.rd_valid_o !== 1'b0 || bus.rd_row_o !== held) begin
      errors++;
      $display("FAIL idle_hold: valid=%b row_held=%b, required 0 1", bus.rd_valid_o, bus.rd_row_o === held);
    end
  endtask

  task automatic test_swap();
    logic [ROW_W-1:0] e;
    drive_cycle(0, 0, 0, 0, 0, 0, '0, 1, 0, 0, 3, 0, 0, e);
    checks++;
    if (bus.perm_o[AW-1:0] !== AW'(3) || bus.perm_o[3*AW +: AW] !== AW'(0) || bus.perm_o !== exp_perm(0)) begin
      errors++;
      $display("FAIL swap_perm: perm_o=%h, required %h", bus.perm_o, exp_perm(0));
    end
    drive_cycle(1, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (bus.rd_row_o !== e || bus.rd_row_o[WD-1:0] !== $realtobits(3.0)) begin
      errors++;
      $display("FAIL swap_read: re0=%h, required %h", bus.rd_row_o[WD-1:0], $realtobits(3.0));
    end
    bus.rd_bank_i = 1'b1; #1;
    checks++;
    if (bus.perm_o !== exp_perm(1)) begin
      errors++;
      $display("FAIL swap_other_bank: perm_o=%h, required %h", bus.perm_o, exp_perm(1));
    end
  endtask

  task automatic test_read_before_write();
    logic [ROW_W-1:0] e, nw;
    nw = rand_row();
    drive_cycle(1, 0, 1, 1, 0, 1, nw, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (bus.rd_row_o !== e) begin
      errors++;
      $display("FAIL rbw_old: got %h, required %h", bus.rd_row_o[31:0], e[31:0]);
    end
    drive_cycle(1, 0, 1, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (bus.rd_row_o !== nw) begin
      errors++;
      $display("FAIL rbw_new: got %h, required %h", bus.rd_row_o[31:0], nw[31:0]);
    end
  endtask

  task automatic test_swap_read();
    logic [ROW_W-1:0] e, old2;
    old2 = lrow[0][2];
    drive_cycle(1, 0, 1, 0, 0, 0, '0, 1, 0, 1, 2, 0, 0, e);
    checks++;
    if (bus.rd_row_o !== e) begin
      errors++;
      $display("FAIL swap_read_pre: got %h, required %h", bus.rd_row_o[31:0], e[31:0]);
    end
    drive_cycle(1, 0, 1, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (bus.rd_row_o !== old2 || e !== old2) begin
      errors++;
      $display("FAIL swap_read_post: got %h, required %h", bus.rd_row_o[31:0], old2[31:0]);
    end
  endtask

  task automatic test_random();
    logic [ROW_W-1:0] e;
    bit rd, wr, sw;
    int rb;
    for (int c = 0; c < 200; c++) begin
      rd = $urandom_range(0, 1) != 0;
      wr = $urandom_range(0, 2) == 0;
      sw = $urandom_range(0, 2) == 0;
      rb = $urandom_range(0, NB - 1);
      drive_cycle(rd, rb, $urandom_range(0, SZ - 1),
                  wr, $urandom_range(0, NB - 1), $urandom_range(0, SZ - 1), rand_row(),
                  sw, $urandom_range(0, NB - 1), $urandom_range(0, SZ - 1), $urandom_range(0, SZ - 1),
                  0, 0, e);
      checks++;
      if (bus.rd_valid_o !== rd || (rd && bus.rd_row_o !== e)) begin
        errors++;
        $display("FAIL random_read c=%0d: valid=%b row_ok=%b, required %b 1", c, bus.rd_valid_o, bus.rd_row_o === e, rd);
      end
      checks++;
      if (bus.perm_o !== exp_perm(rb)) begin
        errors++;
        $display("FAIL random_perm c=%0d: perm_o=%h, required %h", c, bus.perm_o, exp_perm(rb));
      end
    end
  endtask

  task automatic test_clr();
    logic [ROW_W-1:0] e;
    int n;
    drive_cycle(1, 0, 0, 0, 0, 0, '0, 1, 0, 1, 3, 1, 0, e);
    checks++;
    if (bus.rd_row_o !== e || bus.rd_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL clr_same_cycle_read: valid=%b row_ok=%b, required 1 1", bus.rd_valid_o, bus.rd_row_o === e);
    end
    bus.wr_valid_i = 1'b1; bus.wr_bank_i = '0; bus.wr_addr_i = '0; bus.wr_row_i = rand_row();
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 10) begin
      checks++;
      if (bus.busy_o !== 1'b1) begin
        errors++;
        $display("FAIL clr_busy: busy=%b during clear, required 1", bus.busy_o);
      end
      n++;
      @(posedge clk); #1;
    end
    bus.wr_valid_i = 1'b0;
    checks++;
    if (n != SZ) begin
      errors++;
      $display("FAIL clr_ready_low: ready low %0d cycles, required %0d", n, SZ);
    end
    bus.rd_bank_i = '0; #1;
    checks++;
    if (bus.perm_o !== 8'hE4 || exp_perm(0) !== 8'hE4) begin
      errors++;
      $display("FAIL clr_perm: perm_o=%h, required e4", bus.perm_o);
    end
    for (int i = 0; i < SZ; i++) begin
      drive_cycle(1, 0, i, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
      checks++;
      if (bus.rd_row_o !== e) begin
        errors++;
        $display("FAIL clr_read_%0d: got %h, required %h", i, bus.rd_row_o[31:0], e[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [ROW_W-1:0] e, nw;
    drive_cycle(1, 0, 3, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
    drive_cycle(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 1, 1, e);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_values("reset_mid_clr");
    @(posedge clk); #1;
    release_and_init("reset_mid");
`ifdef MAT_ROW_STORE_ZERO_INIT_EN
    drive_cycle(1, 1, 2, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (bus.rd_row_o !== '0) begin
      errors++;
      $display("FAIL zero_init_read: row_nonzero=%b, required 0", |bus.rd_row_o);
    end
`endif
    nw = rand_row();
    drive_cycle(0, 0, 0, 1, 1, 2, nw, 0, 0, 0, 0, 0, 0, e);
    drive_cycle(1, 1, 2, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, e);
    checks++;
    if (bus.rd_row_o !== nw || e !== nw) begin
      errors++;
      $display("FAIL post_reset_rw: got %h, required %h", bus.rd_row_o[31:0], nw[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_swap();
    test_read_before_write();
    test_swap_read();
    test_random();
    test_clr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_row_store.md
Name: mat_row_store

Overview:
- Parametrised, pivot-capable complex-matrix row store feeding the LU/inverse engines.
- Holds NUM_BANKS matrices of SIZE rows; each row is SIZE complex elements {imag,real}, each part WIDTH bits.
- Adds a per-bank logical-to-physical row permutation table, so row swaps during pivoting cost one cycle.
- Supports multi-bank ping-pong: a loader fills one bank while the engine works in another.

Parameters:
- SIZE, 4, matrix dimension (rows per bank, elements per row); power of two, >=2
- WIDTH, 64, bits per real/imag part (IEEE double at default)
- NUM_BANKS, 2, independent matrix banks; >=1
- Derived: ROW_W = SIZE*2*WIDTH; AW = $clog2(SIZE); BW = max(1,$clog2(NUM_BANKS))

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- rd_valid_i  in  1  read request
- rd_bank_i  in  BW  read bank
- rd_addr_i  in  AW  logical read row
- rd_row_o  out  ROW_W  read data {b,a} per element
- rd_valid_o  out  1  read data valid
- rd_addr_o  out  AW  logical row of rd_row_o
- wr_valid_i  in  1  write request
- wr_bank_i  in  BW  write bank
- wr_addr_i  in  AW  logical write row
- wr_row_i  in  ROW_W  write data
- swap_valid_i  in  1  swap logical rows swap_a_i/swap_b_i
- swap_bank_i  in  BW  swap bank
- swap_a_i  in  AW  first logical row
- swap_b_i  in  AW  second logical row
- perm_clr_i  in  1  restore identity permutation of perm_clr_bank_i
- perm_clr_bank_i  in  BW  bank to restore
- perm_o  out  SIZE*AW  permutation of bank rd_bank_i; entry i = physical row of logical i
- ready_o  out  1  store accepts rd/wr/swap/perm_clr this cycle
- busy_o  out  1  high in INIT/CLR states

Behaviour:
- Reset values: rd_row_o=0, rd_valid_o=0, rd_addr_o=0, ready_o=0, busy_o=1; FSM enters INIT; permutation tables are undefined until INIT completes.
- FSM INIT: writes identity (perm[b][i]=i), one entry per bank per cycle, with an index counter 0..SIZE-1. Takes SIZE cycles, then IDLE.
- FSM IDLE: ready_o=1, busy_o=0. perm_clr_i moves to CLR.
- FSM CLR: restores identity in the selected bank over SIZE cycles, ready_o=0, then IDLE.
- Requests asserted while ready_o=0 are ignored, not queued. The requester holds the request until ready_o=1.
- Read: accepted rd_valid_i gives rd_row_o = mem[rd_bank_i][perm[rd_bank_i][rd_addr_i]] with rd_valid_o=1 and rd_addr_o=rd_addr_i exactly 1 cycle later. rd_valid_o is 0 on cycles with no accepted read; rd_row_o holds its last value.
- Write: accepted wr_valid_i writes mem[wr_bank_i][perm[wr_bank_i][wr_addr_i]] at the clock edge.
- Swap: accepted swap_valid_i exchanges perm entries a and b at the clock edge. swap_a_i==swap_b_i is a no-op.
- Same-cycle read, write and swap are all accepted.
- Ordering within one cycle:
  - every address translation uses the pre-edge permutation;
  - a read of the same physical row being written returns OLD data (read-before-write);
  - a swap affects requests from the next cycle onward.
- perm_clr_i in the same cycle as other requests: reads, writes and swaps in that cycle complete, and the swap is then overwritten by CLR.
- perm_o is combinational from the table indexed by rd_bank_i.
- Out-of-range bank (>=NUM_BANKS) on any port: the request is dropped, and a read returns rd_valid_o=1 with rd_row_o=0.
- Reset mid-operation: asynchronous return to reset values and INIT. Memory contents are not guaranteed unless the optional feature is enabled.

Optional Feature:
- Macro MAT_ROW_STORE_ZERO_INIT_EN.
- Defined: INIT also writes an all-zero row at physical row idx of every bank, so reads after reset return 0. CLR clears nothing but the permutation.
- Undefined: data memory has no reset or clear; reads before the first write return X in simulation.

Decomposition:
- Shared package mat_pkg (alongside the LU types):
  - typedef cplx_t: packed struct {logic [WIDTH-1:0] im, re};
  - typedef row_t: cplx_t [SIZE-1:0];
  - typedef enum rs_state_e {INIT, IDLE, CLR};
  - constants for default SIZE/WIDTH.
- One natural sub-module, perm_table: one bank's permutation registers with swap, identity-fill index and read port. Instantiate it NUM_BANKS times.

Test Plan:
- Reset, wait ready_o (SIZE=4, rises 4 cycles after rst_ni) -> perm_o = {3,2,1,0} packed (identity); busy_o falls the same cycle.
- Write rows 0..3 of bank0 with element re=row index (as real), then read 2 -> rd_valid_o 1 cycle later, rd_addr_o=2, rd_row_o equals the written row 2.
- Swap 0<->3 in bank0, next cycle read logical 0 -> returns data written as row 3; perm_o[0]=3, perm_o[3]=0; bank1 perm unchanged.
- Same-cycle write logical 1 (new data) and read logical 1 -> read returns old data; read next cycle returns new data.
- Same-cycle swap 1<->2 and read logical 1 -> returns pre-swap row 1; a following read of logical 1 returns old row 2.
- perm_clr_i on bank0 -> ready_o low for 4 cycles, then perm_o identity. Assert rst_ni low mid-CLR -> outputs at reset values immediately; with MAT_ROW_STORE_ZERO_INIT_EN, a read after INIT returns 0.
